alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter_alu.sv | 22 ++
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: operation codes, data width and FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LATCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester ALU service bus: per-requester request/operands in, grant/done pulses and shared result out.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [1:0]        sel0;
    logic [1:0]        sel1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, sel0, sel1,
        input  gnt0, gnt1, done0, done1, result, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, sel0, sel1,
        output gnt0, gnt1, done0, done1, result, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU (add/sub/and/or); carries and overflow are dropped, results wrap.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           sel,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = '0;
        case (sel)
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters via IDLE->LATCH->EXEC->DONE sequencing.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic              winner_q;
    logic              gnt0_q, gnt1_q, done0_q, done1_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, result_q, alu_out;
    alu_op_e           op_sel_q;
    logic              any_req, grant, pick;

    assign any_req = bus.req0 | bus.req1;
    assign grant   = (state_q == ST_IDLE) && any_req;

`ifdef ALU_ARB_RR_EN
    logic last_served_q;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign pick = (bus.req0 && bus.req1) ? ~last_served_q : bus.req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_q <= 1'b1;
        end else if (grant) begin
            last_served_q <= pick;
        end
    end
`else
    assign pick = ~bus.req0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            winner_q <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= grant && !pick;
            gnt1_q  <= grant && pick;
            done0_q <= (state_q == ST_DONE) && !winner_q;
            done1_q <= (state_q == ST_DONE) && winner_q;
            if (grant) begin
                winner_q <= pick;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_out;
            end
        end
    end

    // Operand snapshot at grant isolates the in-flight op from later input changes.
    always_ff @(posedge clk) begin
        if (grant) begin
            op_a_q   <= pick ? bus.a1 : bus.a0;
            op_b_q   <= pick ? bus.b1 : bus.b0;
            op_sel_q <= alu_op_e'(pick ? bus.sel1 : bus.sel0);
        end
    end

    alu u_alu (
        .a   (op_a_q),
        .b   (op_b_q),
        .sel (op_sel_q),
        .out (alu_out)
    );

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.result = result_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter; expected winners/results come from a policy-level model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   last_m   = 1;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int pick_ref(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef ALU_ARB_RR_EN
        return (last_m == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic wait_grant(input int exp_w, output int lat);
        lat = 0;
        while (!(bus.gnt0 || bus.gnt1) && lat < 8) begin
            tick();
            lat++;
        end
        chk("grant_seen", 32'(lat < 8), 32'd1);
        chk("gnt_select", 32'({bus.gnt1, bus.gnt0}), (exp_w == 0) ? 32'd1 : 32'd2);
        chk("busy_after_gnt", 32'(bus.busy), 32'd1);
        last_m = exp_w;
    endtask

    task automatic wait_done(input int exp_w, input logic [31:0] exp_res);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("no_early_done", 32'({bus.done1, bus.done0}), 32'd0);
        end
        tick();
        chk("done_select", 32'({bus.done1, bus.done0}), (exp_w == 0) ? 32'd1 : 32'd2);
        chk("no_gnt_at_done", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        chk("result", bus.result, exp_res);
    endtask

    initial begin
        int          lat, w, w2;
        bit          r0, r1;
        logic [31:0] e0, e1;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.sel0 = 2'd0; bus.sel1 = 2'd0;

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        chk("rst_done", 32'({bus.done1, bus.done0}), 32'd0);
        rst = 1'b0;

        // Single ADD on requester 0 with exact latency
        bus.a0 = 32'h000003E8; bus.b0 = 32'h000007D0; bus.sel0 = 2'd0; bus.req0 = 1'b1;
        wait_grant(pick_ref(1, 0), lat);
        chk("lat_gnt", 32'(lat), 32'd1);
        wait_done(0, 32'h00000BB8);
        bus.req0 = 1'b0;
        tick();
        chk("result_held", bus.result, 32'h00000BB8);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // SUB wrap, operands altered after grant
        bus.a1 = 32'd0; bus.b1 = 32'd1; bus.sel1 = 2'd1; bus.req1 = 1'b1;
        wait_grant(pick_ref(0, 1), lat);
        bus.a1 = 32'd5; bus.b1 = $urandom; bus.sel1 = 2'd3;
        wait_done(1, 32'hFFFFFFFF);
        bus.req1 = 1'b0;

        // Simultaneous AND/OR requests
        bus.a0 = 32'hF0F0F0F0; bus.b0 = 32'h0F0F0F0F; bus.sel0 = 2'd2;
        bus.a1 = 32'hF0F0F0F0; bus.b1 = 32'h0F0F0F0F; bus.sel1 = 2'd3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        w = pick_ref(1, 1);
        wait_grant(w, lat);
        wait_done(w, (w == 0) ? 32'h00000000 : 32'hFFFFFFFF);
        if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        w2 = pick_ref(w == 1, w == 0);
        wait_grant(w2, lat);
        wait_done(w2, (w2 == 0) ? 32'h00000000 : 32'hFFFFFFFF);
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Both held continuously across four services
        bus.a0 = $urandom; bus.b0 = $urandom; bus.sel0 = 2'($urandom_range(0, 3));
        bus.a1 = $urandom; bus.b1 = $urandom; bus.sel1 = 2'($urandom_range(0, 3));
        e0 = ref_alu(bus.sel0, bus.a0, bus.b0);
        e1 = ref_alu(bus.sel1, bus.a1, bus.b1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = pick_ref(1, 1);
            wait_grant(w, lat);
            chk("held_lat", 32'(lat), 32'd1);
            wait_done(w, (w == 0) ? e0 : e1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Requester drops req right after grant
        bus.a0 = $urandom; bus.b0 = $urandom; bus.sel0 = 2'($urandom_range(0, 3));
        e0 = ref_alu(bus.sel0, bus.a0, bus.b0);
        bus.req0 = 1'b1;
        wait_grant(pick_ref(1, 0), lat);
        bus.req0 = 1'b0; bus.a0 = $urandom;
        wait_done(0, e0);

        // Randomized request patterns
        for (int it = 0; it < 16; it++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.a0 = $urandom; bus.b0 = $urandom; bus.sel0 = 2'($urandom_range(0, 3));
            bus.a1 = $urandom; bus.b1 = $urandom; bus.sel1 = 2'($urandom_range(0, 3));
            e0 = ref_alu(bus.sel0, bus.a0, bus.b0);
            e1 = ref_alu(bus.sel1, bus.a1, bus.b1);
            bus.req0 = r0; bus.req1 = r1;
            w = pick_ref(r0, r1);
            wait_grant(w, lat);
            chk("rand_lat", 32'(lat), 32'd1);
            if (w == 0) begin bus.a0 = $urandom; bus.sel0 = 2'($urandom_range(0, 3)); end
            else        begin bus.b1 = $urandom; bus.sel1 = 2'($urandom_range(0, 3)); end
            wait_done(w, (w == 0) ? e0 : e1);
            if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
            if (r0 && r1) begin
                w2 = 1 - w;
                wait_grant(pick_ref(w2 == 0, w2 == 1), lat);
                wait_done(w2, (w2 == 0) ? e0 : e1);
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
        end

        // Reset during EXEC aborts the operation
        bus.a0 = 32'h12345678; bus.b0 = 32'h11111111; bus.sel0 = 2'd0; bus.req0 = 1'b1;
        wait_grant(0, lat);
        tick();
        rst = 1'b1; bus.req0 = 1'b0;
        tick();
        rst = 1'b0;
        last_m = 1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_done", 32'({bus.done1, bus.done0}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'({bus.done1, bus.done0}), 32'd0);
        end
        bus.req0 = 1'b1;
        wait_grant(pick_ref(1, 0), lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        wait_done(0, 32'h23456789);
        bus.req0 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
